lcd1602_responder: RTL

//  HD44780/LCD1602-compatible bus responder: the receiving end of the 8-bit, write-only LCD interface our display

---
 rtl/lcd1602_pkg.sv | 57 +++++
 rtl/lcd1602_responder_sync.sv | 53 +++++
 rtl/lcd1602_responder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/lcd1602_pkg.sv
// Shared constants, FSM state type and address helpers for the LCD1602 bus responder.
package lcd1602_pkg;

  localparam logic [6:0]  ROW1_BASE = 7'h00;
  localparam logic [6:0]  ROW2_BASE = 7'h40;
  localparam int unsigned ROW_LEN   = 40;
  localparam int unsigned DDRAM_LEN = 2 * ROW_LEN;
  localparam logic [7:0]  SPACE     = 8'h20;
  localparam logic [6:0]  LINE1_END = 7'h0F;
  localparam logic [6:0]  LINE2_END = 7'h4F;

  localparam logic [7:0] CMD_DDRAM_MASK = 8'h80, CMD_DDRAM_MATCH = 8'h80;
  localparam logic [7:0] CMD_CGRAM_MASK = 8'hC0, CMD_CGRAM_MATCH = 8'h40;
  localparam logic [7:0] CMD_FUNC_MASK  = 8'hE0, CMD_FUNC_MATCH  = 8'h20;
  localparam logic [7:0] CMD_SHIFT_MASK = 8'hF0, CMD_SHIFT_MATCH = 8'h10;
  localparam logic [7:0] CMD_DISP_MASK  = 8'hF8, CMD_DISP_MATCH  = 8'h08;
  localparam logic [7:0] CMD_ENTRY_MASK = 8'hFC, CMD_ENTRY_MATCH = 8'h04;
  localparam logic [7:0] CMD_HOME_MASK  = 8'hFE, CMD_HOME_MATCH  = 8'h02;
  localparam logic [7:0] CMD_CLEAR_MASK = 8'hFF, CMD_CLEAR_MATCH = 8'h01;

  typedef enum logic [1:0] {
    ST_WAIT_FUNC,
    ST_IDLE,
    ST_BUSY
  } lcd_state_t;

  function automatic logic is_cmd(input logic [7:0] d, input logic [7:0] mask,
                                  input logic [7:0] match);
    return (d & mask) == match;
  endfunction

  function automatic logic ac_valid(input logic [6:0] ac);
    return (ac < ROW1_BASE + 7'(ROW_LEN)) ||
           (ac >= ROW2_BASE && ac < ROW2_BASE + 7'(ROW_LEN));
  endfunction

  function automatic logic [6:0] ac_to_index(input logic [6:0] ac);
    return (ac < ROW2_BASE) ? ac : 7'(ac - ROW2_BASE + 7'(ROW_LEN));
  endfunction

  function automatic logic [6:0] rd_to_index(input logic [4:0] r);
    return r[4] ? 7'({3'b000, r[3:0]}) + 7'(ROW_LEN) : {3'b000, r[3:0]};
  endfunction

  // Each row is a 40-byte ring; stepping off either end lands on the other row.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac == ROW1_BASE + 7'(ROW_LEN - 1)) return ROW2_BASE;
      if (ac == ROW2_BASE + 7'(ROW_LEN - 1)) return ROW1_BASE;
      return ac + 7'd1;
    end
    if (ac == ROW1_BASE) return ROW2_BASE + 7'(ROW_LEN - 1);
    if (ac == ROW2_BASE) return ROW1_BASE + 7'(ROW_LEN - 1);
    return ac - 7'd1;
  endfunction

endpackage

// File: rtl/lcd1602_responder_sync.sv
// Synchronizes the LCD pins, detects EN falling edges and flags EN pulses that were too short.
module lcd_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_EN_HIGH = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  output logic       strobe,
  output logic       rs,
  output logic       rw,
  output logic [7:0] data,
  output logic       short
);

  localparam int unsigned CW       = $clog2(MIN_EN_HIGH + 1);
  localparam logic [10:0] SYNC_RST = 11'h400;

  logic [10:0]   sync_q [SYNC_STAGES];
  logic          en_s;
  logic          en_prev;
  logic          armed;
  logic [CW-1:0] high_cnt;

  // Chain resets with EN high and edges are ignored until EN is seen low,
  // so a pulse already in flight at reset release never becomes a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
      en_prev  <= 1'b1;
      armed    <= 1'b0;
      high_cnt <= '0;
    end else begin
      sync_q[0] <= {lcd_en, lcd_rs, lcd_rw, lcd_data};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      en_prev <= en_s;
      if (!en_s) armed <= 1'b1;
      if (!en_s) high_cnt <= '0;
      else if (high_cnt != CW'(MIN_EN_HIGH)) high_cnt <= high_cnt + 1'b1;
    end
  end

  assign en_s   = sync_q[SYNC_STAGES-1][10];
  assign rs     = sync_q[SYNC_STAGES-1][9];
  assign rw     = sync_q[SYNC_STAGES-1][8];
  assign data   = sync_q[SYNC_STAGES-1][7:0];
  assign strobe = en_prev & ~en_s & armed;
  assign short  = high_cnt < CW'(MIN_EN_HIGH);

endmodule

// File: rtl/lcd1602_responder.sv
// LCD1602 write-bus responder: FSM with busy emulation, instruction decode, DDRAM and visible-cell read port.
module lcd1602_responder
  import lcd1602_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned MIN_EN_HIGH  = 12,
  parameter int unsigned CLR_BUSY_CYC = 60000,
  parameter int unsigned CMD_BUSY_CYC = 2000
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       LCD_EN,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_Data,
  input  logic [4:0] Rd_Addr,
  output logic [7:0] Rd_Char,
  output logic       Disp_On,
  output logic       Func_Ok,
  output logic [6:0] AC,
  output logic       Busy,
  output logic       Wr_Strobe,
  output logic [1:0] Line_Done,
  output logic       Err
);

  localparam int unsigned BW = $clog2((CLR_BUSY_CYC > CMD_BUSY_CYC) ? CLR_BUSY_CYC : CMD_BUSY_CYC);

  logic       bus_strobe, bus_rs, bus_rw, bus_short;
  logic [7:0] bus_data;

  lcd_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_EN_HIGH(MIN_EN_HIGH)
  ) u_sync (
    .clk     (CLK),
    .rst_n   (RST_n),
    .lcd_en  (LCD_EN),
    .lcd_rs  (LCD_RS),
    .lcd_rw  (LCD_RW),
    .lcd_data(LCD_Data),
    .strobe  (bus_strobe),
    .rs      (bus_rs),
    .rw      (bus_rw),
    .data    (bus_data),
    .short   (bus_short)
  );

  lcd_state_t    state_q, state_d;
  logic [BW-1:0] busy_q, busy_d;
  logic [6:0]    ac_d;
  logic          id_q, id_d, disp_d, func_d, err_d;
  logic          accept, long_busy, ram_we, ram_clear;
  logic [1:0]    line_done_d;
  logic [7:0]    ddram [DDRAM_LEN];

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    ac_d        = AC;
    id_d        = id_q;
    disp_d      = Disp_On;
    func_d      = Func_Ok;
    err_d       = Err;
    accept      = 1'b0;
    long_busy   = 1'b0;
    ram_we      = 1'b0;
    ram_clear   = 1'b0;
    line_done_d = '0;

    if (state_q == ST_BUSY) begin
      if (busy_q == '0) state_d = ST_IDLE;
      else              busy_d  = busy_q - 1'b1;
    end

    if (bus_strobe) begin
      if (bus_rw || bus_short) err_d = 1'b1;
      else begin
        case (state_q)
          ST_WAIT_FUNC: begin
            if (!bus_rs && is_cmd(bus_data, CMD_FUNC_MASK, CMD_FUNC_MATCH)) accept = 1'b1;
            else err_d = 1'b1;
          end
          ST_BUSY: err_d = 1'b1;
          default: accept = 1'b1;
        endcase
      end
    end

    if (accept) begin
      if (bus_rs) begin
        ram_we      = 1'b1;
        line_done_d = {AC == LINE2_END, AC == LINE1_END};
        ac_d        = ac_step(AC, id_q);
      end else if (is_cmd(bus_data, CMD_DDRAM_MASK, CMD_DDRAM_MATCH)) begin
        if (ac_valid(bus_data[6:0])) ac_d = bus_data[6:0];
        else begin
          ac_d  = '0;
          err_d = 1'b1;
        end
      end else if (is_cmd(bus_data, CMD_CGRAM_MASK, CMD_CGRAM_MATCH)) begin
        ac_d = AC;
      end else if (is_cmd(bus_data, CMD_FUNC_MASK, CMD_FUNC_MATCH)) begin
        func_d = bus_data[4] & bus_data[3];
      end else if (is_cmd(bus_data, CMD_SHIFT_MASK, CMD_SHIFT_MATCH)) begin
        if (!bus_data[3]) ac_d = ac_step(AC, bus_data[2]);
      end else if (is_cmd(bus_data, CMD_DISP_MASK, CMD_DISP_MATCH)) begin
        disp_d = bus_data[2];
      end else if (is_cmd(bus_data, CMD_ENTRY_MASK, CMD_ENTRY_MATCH)) begin
        id_d = bus_data[1];
      end else if (is_cmd(bus_data, CMD_HOME_MASK, CMD_HOME_MATCH)) begin
        ac_d      = '0;
        long_busy = 1'b1;
      end else if (is_cmd(bus_data, CMD_CLEAR_MASK, CMD_CLEAR_MATCH)) begin
        ram_clear = 1'b1;
        ac_d      = '0;
        id_d      = 1'b1;
        long_busy = 1'b1;
      end
      state_d = (state_q == ST_WAIT_FUNC) ? ST_IDLE : ST_BUSY;
      busy_d  = long_busy ? BW'(CLR_BUSY_CYC - 1) : BW'(CMD_BUSY_CYC - 1);
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= ST_WAIT_FUNC;
      busy_q    <= '0;
      AC        <= '0;
      id_q      <= 1'b1;
      Disp_On   <= 1'b0;
      Func_Ok   <= 1'b0;
      Err       <= 1'b0;
      Wr_Strobe <= 1'b0;
      Line_Done <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      AC        <= ac_d;
      id_q      <= id_d;
      Disp_On   <= disp_d;
      Func_Ok   <= func_d;
      Err       <= err_d;
      Wr_Strobe <= accept;
      Line_Done <= line_done_d;
    end
  end

  assign Busy = (state_q == ST_BUSY);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int unsigned i = 0; i < DDRAM_LEN; i++) ddram[i] <= SPACE;
      Rd_Char <= SPACE;
    end else begin
      if (ram_clear) begin
        for (int unsigned i = 0; i < DDRAM_LEN; i++) ddram[i] <= SPACE;
      end else if (ram_we) begin
        ddram[ac_to_index(AC)] <= bus_data;
      end
      Rd_Char <= ddram[rd_to_index(Rd_Addr)];
    end
  end

endmodule
